// File: rtl/demux_collect5_2_if.sv
// Handshake bundle for demux_collect5_2: symbol side in, collected word side out.
// The master modport drives symbols and drains words; the slave modport is the collector.
interface demux_collect5_2_if #(
  parameter int N_LANES = 5,
  parameter int LANE_W  = 2,
  parameter int SEL_W   = $clog2(N_LANES)
);
  logic                      in_valid;
  logic [LANE_W-1:0]         in_data;
  logic                      in_ready;
  logic                      flush;
  logic [N_LANES*LANE_W-1:0] out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [SEL_W-1:0]          lane;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_data, out_valid, lane
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_data, out_valid, lane
  );
endinterface

// File: rtl/demux_collect5_2.sv
// Lane-by-lane collector of a serial symbol stream into an N_LANES*LANE_W word.
// Define DEMUX_OVERLAP_EN to accept lane 0 of the next word on the drain cycle.
module demux_collect5_2 #(
  parameter int N_LANES = 5,
  parameter int LANE_W  = 2,
  parameter int SEL_W   = $clog2(N_LANES)
) (
  input logic              clk,
  input logic              rst,
  demux_collect5_2_if.slave link_io
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(N_LANES - 1);

  state_e                    state_q;
  logic [SEL_W-1:0]          lane_q;
  logic [N_LANES*LANE_W-1:0] outData_q;
  logic                      outValid_q;
  logic                      overlapReady;
  logic                      accept;

`ifdef DEMUX_OVERLAP_EN
  // The word being drained frees the buffer, so its lane 0 can be refilled in the same cycle.
  assign overlapReady = (state_q == HOLD) && link_io.out_ready;
`else
  assign overlapReady = 1'b0;
`endif

  assign link_io.in_ready  = !rst && ((state_q == FILL) || overlapReady);
  assign accept            = link_io.in_valid && link_io.in_ready;
  assign link_io.out_data  = outData_q;
  assign link_io.out_valid = outValid_q;
  assign link_io.lane      = lane_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      lane_q     <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
    end else if (link_io.flush) begin
      state_q    <= FILL;
      lane_q     <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            for (int k = 0; k < N_LANES; k++) begin
              if (lane_q == SEL_W'(k)) begin
                outData_q[k*LANE_W +: LANE_W] <= link_io.in_data;
              end
            end
            if (lane_q == LAST_LANE) begin
              lane_q     <= '0;
              state_q    <= HOLD;
              outValid_q <= 1'b1;
            end else begin
              lane_q <= lane_q + SEL_W'(1);
            end
          end
        end
        HOLD: begin
          if (link_io.out_ready) begin
            state_q    <= FILL;
            outValid_q <= 1'b0;
            // Only reachable with the overlap build; otherwise in_ready is low here.
            if (accept) begin
              outData_q[LANE_W-1:0] <= link_io.in_data;
              lane_q                <= SEL_W'(1);
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_collect5_2.sv
// Self-checking bench for demux_collect5_2 with a queue-based reference model.
// Build with +define+DEMUX_OVERLAP_EN to check the overlapped-drain variant.
module tb_demux_collect5_2;

`ifdef DEMUX_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  demux_collect5_2_if #(.N_LANES(5), .LANE_W(2)) bus ();

  demux_collect5_2 #(.N_LANES(5), .LANE_W(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .link_io (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 5:2 mux: selects the 2-bit field s of a collected word.
  function automatic logic [1:0] muxSel(input logic [9:0] w, input int s);
    logic [9:0] sh;
    sh = w >> (2 * s);
    return sh[1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = 2'b00;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idleInputs();
    rst = 1'b1;
    #12;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.lane !== 3'd0) begin errors++; $display("[TB] FAIL reset_lane: got %0d expected 0", bus.lane); end
    checks++;
    if (bus.out_data !== 10'd0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 000", bus.out_data); end
    rst = 1'b0;
    step();
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_reset_midfill();
    bus.in_valid = 1'b1;
    bus.in_data  = 2'b11;
    step();
    bus.in_data  = 2'b10;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.lane !== 3'd2) begin errors++; $display("[TB] FAIL midfill_lane: got %0d expected 2", bus.lane); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_data !== 10'd0 || bus.lane !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midfill_async_reset: got data=%h lane=%0d ov=%b ir=%b expected 000/0/0/0",
               bus.out_data, bus.lane, bus.out_valid, bus.in_ready);
    end
    #2 rst = 1'b0;
    step();
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midfill_release_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_basic_fill();
    logic [1:0] syms [5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    logic [9:0] expWord = 10'b01_00_11_10_01;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = syms[i];
      step();
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== expWord) begin
      errors++;
      $display("[TB] FAIL fill_word: got ov=%b data=%b expected 1/%b", bus.out_valid, bus.out_data, expWord);
    end
    bus.in_data = 2'b11;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== expWord) begin
        errors++;
        $display("[TB] FAIL fill_hold_%0d: got ir=%b ov=%b data=%b expected 0/1/%b",
                 i, bus.in_ready, bus.out_valid, bus.out_data, expWord);
      end
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.lane !== 3'd0 || bus.out_data !== expWord) begin
      errors++;
      $display("[TB] FAIL fill_drain: got ov=%b lane=%0d data=%b expected 0/0/%b",
               bus.out_valid, bus.lane, bus.out_data, expWord);
    end
  endtask

  task automatic test_gapped();
    logic [1:0] syms [5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    int accepted = 0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_data  = (i % 2 == 0) ? syms[i/2] : 2'($urandom);
      step();
      if (i % 2 == 0) accepted++;
      checks++;
      if (bus.lane !== 3'(accepted % 5)) begin
        errors++;
        $display("[TB] FAIL gapped_lane_%0d: got %0d expected %0d", i, bus.lane, accepted % 5);
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 10'b01_00_11_10_01) begin
      errors++;
      $display("[TB] FAIL gapped_word: got ov=%b data=%b expected 1/0100111001", bus.out_valid, bus.out_data);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 2'b10;
      step();
    end
    checks++;
    if (bus.lane !== 3'd3) begin errors++; $display("[TB] FAIL flush_pre_lane: got %0d expected 3", bus.lane); end
    bus.flush   = 1'b1;
    bus.in_data = 2'b11;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.lane !== 3'd0 || bus.out_data !== 10'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_partial: got lane=%0d data=%h ov=%b expected 0/000/0", bus.lane, bus.out_data, bus.out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 2'b01;
      step();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_refill: got ov=%b expected 1", bus.out_valid); end
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.lane !== 3'd0 || bus.out_data !== 10'd0) begin
      errors++;
      $display("[TB] FAIL flush_held: got ov=%b lane=%0d data=%h expected 0/0/000", bus.out_valid, bus.lane, bus.out_data);
    end
  endtask

  // Model: a word is the queue of symbols accepted since the last drain; it is held once it has 5.
  task automatic test_mux_roundtrip();
    logic [1:0] syms[$];
    bit         held  = 1'b0;
    int         words = 0;
    int         cyc   = 0;
    bit         expReady;
    bit         ivld;
    bit         ordy;
    logic [1:0] d;
    while (words < 200 && cyc < 20000) begin
      checks++;
      if (bus.out_valid !== held) begin
        errors++;
        $display("[TB] FAIL rand_out_valid cyc %0d: got %b expected %b", cyc, bus.out_valid, held);
      end
      if (!held) begin
        checks++;
        if (bus.lane !== 3'(syms.size())) begin
          errors++;
          $display("[TB] FAIL rand_lane cyc %0d: got %0d expected %0d", cyc, bus.lane, syms.size());
        end
      end
      ivld = ($urandom_range(0, 3) != 0);
      ordy = $urandom_range(0, 1) != 0;
      d    = 2'($urandom);
      bus.in_valid  = ivld;
      bus.in_data   = d;
      bus.out_ready = ordy;
      #1;
      expReady = !held || (OVERLAP && ordy);
      checks++;
      if (bus.in_ready !== expReady) begin
        errors++;
        $display("[TB] FAIL rand_in_ready cyc %0d: got %b expected %b", cyc, bus.in_ready, expReady);
      end
      if (held && ordy) begin
        for (int k = 0; k < 5; k++) begin
          checks++;
          if (muxSel(bus.out_data, k) !== syms[k]) begin
            errors++;
            $display("[TB] FAIL rand_mux word %0d s=%0d: got %b expected %b", words, k, muxSel(bus.out_data, k), syms[k]);
          end
        end
        syms.delete();
        held = 1'b0;
        words++;
      end
      if (ivld && expReady) begin
        syms.push_back(d);
        if (syms.size() == 5) held = 1'b1;
      end
      step();
      cyc++;
    end
    checks++;
    if (words < 200) begin
      errors++;
      $display("[TB] FAIL rand_budget: got %0d words expected 200", words);
    end
    idleInputs();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    int         period = OVERLAP ? 5 : 6;
    int         hits[$];
    bit         ov;
    logic [1:0] d;
    idleInputs();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      ov = bus.out_valid;
      d  = 2'($urandom);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_data   = d;
      if (ov) hits.push_back(cyc);
      step();
      if (ov) begin
        checks++;
        if (OVERLAP && (bus.lane !== 3'd1 || bus.out_data[1:0] !== d)) begin
          errors++;
          $display("[TB] FAIL b2b_overlap_lane0 cyc %0d: got lane=%0d lane0=%b expected 1/%b", cyc, bus.lane, bus.out_data[1:0], d);
        end else if (!OVERLAP && bus.lane !== 3'd0) begin
          errors++;
          $display("[TB] FAIL b2b_bubble_lane cyc %0d: got %0d expected 0", cyc, bus.lane);
        end
      end
    end
    idleInputs();
    checks++;
    if (hits.size() < 3 || hits[0] != 5) begin
      errors++;
      $display("[TB] FAIL b2b_first_word: got %0d words first at %0d expected >=3 first at 5",
               hits.size(), (hits.size() > 0) ? hits[0] : -1);
    end
    for (int i = 1; i < hits.size(); i++) begin
      checks++;
      if (hits[i] - hits[i-1] != period) begin
        errors++;
        $display("[TB] FAIL b2b_period %0d: got %0d cycles expected %0d", i, hits[i] - hits[i-1], period);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    test_reset();
    test_reset_midfill();
    test_basic_fill();
    test_gapped();
    test_flush();
    test_mux_roundtrip();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
